// File: rtl/stream_unpack_pkg.sv
// rtl/stream_unpack_pkg.sv - shared types, default sizes and width helper for the stream unpacker
package stream_unpack_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, SKIP} state_t;

    localparam int STREAM_WIDTH = 32;
    localparam int STREAM_DEPTH = 11;

    // Occupancy must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_unpack_fifo.sv
// rtl/stream_unpack_fifo.sv - bounded circular queue with push/pop, full/empty and occupancy
module stream_unpack_fifo
    import stream_unpack_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = STREAM_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full queue is accepted.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_unpack_queue.sv
// rtl/stream_unpack_queue.sv - serial LSB-first word unpacker into a bounded queue; STREAM_UNPACK_STATS_EN adds frames_done
module stream_unpack_queue
    import stream_unpack_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = STREAM_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_valid,
    input  logic                        bit_in,
    input  logic                        bit_last,
    input  logic                        err_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        frame_err
`ifdef STREAM_UNPACK_STATS_EN
    ,
    output logic [15:0]                 frames_done
`endif
);

    localparam int BW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic             shift_en;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             set_ovf;
    logic             set_ferr;

    assign word      = {bit_in, sh[WIDTH-1:1]};
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        push        = 1'b0;
        set_ovf     = 1'b0;
        set_ferr    = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (bit_valid) begin
                    shift_en = 1'b1;
                    if (state == SHIFT && bit_cnt == BW'(WIDTH - 1)) begin
                        bit_cnt_nxt = '0;
                        if (!full || pop) begin
                            push      = 1'b1;
                            state_nxt = bit_last ? IDLE : SHIFT;
                        end else begin
                            set_ovf   = 1'b1;
                            state_nxt = bit_last ? IDLE : SKIP;
                        end
                    end else if (bit_last) begin
                        set_ferr    = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        state_nxt   = SHIFT;
                    end
                end
            end
            SKIP: begin
                if (bit_valid && bit_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (shift_en) begin
                sh <= word;
            end
            // A set event in the same cycle as err_clr keeps the flag set.
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef STREAM_UNPACK_STATS_EN
    logic frame_done;
    assign frame_done = (state == SHIFT) && bit_valid && bit_last && (bit_cnt == BW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_done <= '0;
        end else if (frame_done) begin
            frames_done <= frames_done + 16'd1;
        end
    end
`endif

    stream_unpack_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_stream_unpack_queue.sv
// tb/tb_stream_unpack_queue.sv - directed table and sequence checks for stream_unpack_queue
module tb_stream_unpack_queue;

    logic        clk;
    logic        rst;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_last;
    logic        err_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        frame_err;
`ifdef STREAM_UNPACK_STATS_EN
    logic [15:0] frames_done;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [31:0] seq;   // bit 31 is the first bit on the wire
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [5];
    logic [31:0] model [$];
    logic [31:0] vals  [12];

    stream_unpack_queue dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_last  (bit_last),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
`ifdef STREAM_UNPACK_STATS_EN
        ,
        .frames_done (frames_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic l);
        bit_valid = 1'b1;
        bit_in    = b;
        bit_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        bit_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int i = 0; i < 32; i++) begin
            send_bit(w[i], last && (i == 31));
        end
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        err_clr   = 1'b0;
        out_ready = 1'b0;
        idle();

        tbl[0] = '{seq: 32'h8000_0000, exp: 32'h0000_0001};
        tbl[1] = '{seq: 32'hF77D_B57B, exp: 32'hDEAD_BEEF};
        tbl[2] = '{seq: 32'hFF00_0000, exp: 32'h0000_00FF};
        tbl[3] = '{seq: 32'h1E6A_2C48, exp: 32'h1234_5678};
        tbl[4] = '{seq: 32'h0000_0001, exp: 32'h8000_0000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset count", {28'd0, count}, 32'd0);
        chk("reset overflow", {31'd0, overflow}, 32'd0);
        chk("reset frame_err", {31'd0, frame_err}, 32'd0);

        // Single-word frames from the table.
        for (int v = 0; v < 5; v++) begin
            for (int i = 31; i >= 0; i--) begin
                send_bit(tbl[v].seq[i], i == 0);
            end
            idle();
            chk("tbl out_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl out_data", out_data, tbl[v].exp);
            chk("tbl count", {28'd0, count}, 32'd1);
            pop_one();
            chk("tbl count after pop", {28'd0, count}, 32'd0);
        end

        // Multi-word frame, then three back-to-back pops.
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1);
        idle();
        chk("multi count", {28'd0, count}, 32'd3);
        out_ready = 1'b1;
        chk("multi pop0", out_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("multi pop1", out_data, 32'h0000_0000);
        chk("multi count2", {28'd0, count}, 32'd2);
        @(posedge clk); #1;
        chk("multi pop2", out_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("multi drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Fill to 11, overflow on the 12th, skip the tail of the frame.
        for (int k = 0; k < 12; k++) begin
            vals[k] = 32'h100 + k;
        end
        for (int k = 0; k < 12; k++) begin
            send_word(vals[k], 1'b0);
            if (k < 11) model.push_back(vals[k]);
            if (k == 10) begin
                chk("fill count11", {28'd0, count}, 32'd11);
                chk("fill no overflow", {31'd0, overflow}, 32'd0);
            end
        end
        chk("overflow set", {31'd0, overflow}, 32'd1);
        chk("overflow count", {28'd0, count}, 32'd11);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, i == 4);
        end
        idle();
        chk("skip no frame_err", {31'd0, frame_err}, 32'd0);
        chk("skip count", {28'd0, count}, 32'd11);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_clr overflow", {31'd0, overflow}, 32'd0);
        chk("full head", out_data, model[0]);

        // Word completes while full with a simultaneous pop.
        for (int i = 0; i < 31; i++) begin
            send_bit(1'(32'hCAFE_0012 >> i), 1'b0);
        end
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        out_ready = 1'b0;
        idle();
        void'(model.pop_front());
        model.push_back(32'hCAFE_0012);
        chk("simul count", {28'd0, count}, 32'd11);
        chk("simul overflow", {31'd0, overflow}, 32'd0);
        for (int k = 0; k < 11; k++) begin
            chk("drain data", out_data, model.pop_front());
            pop_one();
        end
        chk("drain empty", {31'd0, out_valid}, 32'd0);

        // Short frame, then a good frame.
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1, i == 5);
        end
        idle();
        chk("short frame_err", {31'd0, frame_err}, 32'd1);
        chk("short count", {28'd0, count}, 32'd0);
        send_word(32'h0BAD_F00D, 1'b1);
        idle();
        chk("after short count", {28'd0, count}, 32'd1);
        chk("after short data", out_data, 32'h0BAD_F00D);
        chk("frame_err sticky", {31'd0, frame_err}, 32'd1);
        pop_one();

        // Reset in the middle of a word with two words queued.
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, 1'b0);
        end
        chk("pre-reset count", {28'd0, count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async count", {28'd0, count}, 32'd0);
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async frame_err", {31'd0, frame_err}, 32'd0);
        chk("async overflow", {31'd0, overflow}, 32'd0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(32'h5555_AAAA, 1'b1);
        idle();
        chk("post-reset count", {28'd0, count}, 32'd1);
        chk("post-reset data", out_data, 32'h5555_AAAA);
        chk("post-reset frame_err", {31'd0, frame_err}, 32'd0);
        pop_one();
        chk("post-reset drained", {28'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
